// File: rtl/hamming_error_logger_if.sv
// Record drain port of the Hamming error logger: show-ahead valid/ready stream of
// {timestamp, syndrome, counter} records.
interface hamming_error_logger_if #(
    parameter int unsigned REC_WIDTH = 44
);
    logic                 rec_valid;
    logic [REC_WIDTH-1:0] rec_data;
    logic                 rec_ready;

    modport master (
        output rec_valid,
        output rec_data,
        input  rec_ready
    );

    modport slave (
        input  rec_valid,
        input  rec_data,
        output rec_ready
    );
endinterface

// File: rtl/hamming_error_logger.sv
// Captures one {timestamp, syndrome, counter} record per error assertion seen while the
// counter is paused, buffers records in a small FIFO and keeps saturating statistics.
module hamming_error_logger #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned PARITY_BITS = (WIDTH / 4) * 3,
    parameter int unsigned TS_WIDTH    = 16,
    parameter int unsigned DEPTH       = 4,
    localparam int unsigned REC_WIDTH  = TS_WIDTH + PARITY_BITS + WIDTH,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       counter,
    input  logic [PARITY_BITS-1:0] syndrome,
    input  logic                   error_detected,
    input  logic                   clear,
    hamming_error_logger_if.master rec,
    output logic [15:0]            event_cnt,
    output logic [7:0]             overflow_cnt,
    output logic [AW:0]            fifo_level
);

    typedef enum logic [0:0] {StIdle, StLogged} state_e;

    state_e               state_q, state_d;
    logic [TS_WIDTH-1:0]  ts_q;
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [15:0]          event_q, event_d;
    logic [7:0]           overflow_q, overflow_d;
    logic [REC_WIDTH-1:0] mem_q [DEPTH];

    logic qualified;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Only one event per error assertion: LOGGED blocks requalification.
    assign qualified = (state_q == StIdle) && error_detected && !enable;
    assign pop       = !empty && rec.rec_ready;
    // Full FIFO still accepts when the head leaves in the same cycle.
    assign push      = qualified && (!full || pop);
    assign drop      = qualified && full && !pop;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (qualified) begin
                    state_d = StLogged;
                end
            end
            StLogged: begin
                if (!error_detected || enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        event_d    = event_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            event_d    = '0;
            overflow_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
            end
            if (qualified && (event_q != 16'hFFFF)) begin
                event_d = event_q + 16'd1;
            end
            if (drop && (overflow_q != 8'hFF)) begin
                overflow_d = overflow_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            event_q    <= '0;
            overflow_q <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + TS_WIDTH'(1);
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            event_q    <= event_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale entries on rec_data.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {ts_q, syndrome, counter};
        end
    end

    always_comb begin
        rec.rec_valid = !empty;
        rec.rec_data  = '0;
        if (!empty) begin
            rec.rec_data = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    assign event_cnt    = event_q;
    assign overflow_cnt = overflow_q;
    assign fifo_level   = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_hamming_error_logger.sv
// Directed bench for hamming_error_logger: one-shot logging, overflow, enable gating,
// full-with-pop, clear priority and asynchronous reset.
module tb_hamming_error_logger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] counter;
    logic [11:0] syndrome;
    logic        error_detected;
    logic        clear;
    logic [15:0] event_cnt;
    logic [7:0]  overflow_cnt;
    logic [2:0]  fifo_level;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] ts_model;
    logic [43:0] exp_q [$];
    logic [43:0] held;

    hamming_error_logger_if #(.REC_WIDTH(44)) rec_if ();

    hamming_error_logger #(
        .WIDTH   (16),
        .TS_WIDTH(16),
        .DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .counter       (counter),
        .syndrome      (syndrome),
        .error_detected(error_detected),
        .clear         (clear),
        .rec           (rec_if.master),
        .event_cnt     (event_cnt),
        .overflow_cnt  (overflow_cnt),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    // Free-running timestamp reference: counts every clock since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_model <= '0;
        else        ts_model <= ts_model + 16'd1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated error pulse while paused; acc says whether the FIFO should take it.
    task automatic ev(input logic [15:0] c, input logic [11:0] s, input bit acc);
        counter        = c;
        syndrome       = s;
        enable         = 1'b0;
        error_detected = 1'b1;
        if (acc) exp_q.push_back({ts_model, s, c});
        tick();
        error_detected = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            check_eq("drain_valid", 64'(rec_if.rec_valid), 64'd1);
            check_eq("drain_data", 64'(rec_if.rec_data), 64'(exp_q.pop_front()));
            rec_if.rec_ready = 1'b1;
            tick();
            rec_if.rec_ready = 1'b0;
        end
        check_eq("drain_empty", 64'(rec_if.rec_valid), 64'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        rst_n            = 1'b0;
        enable           = 1'b1;
        counter          = '0;
        syndrome         = '0;
        error_detected   = 1'b0;
        clear            = 1'b0;
        rec_if.rec_ready = 1'b0;
        #12;
        check_eq("rst_valid", 64'(rec_if.rec_valid), 64'd0);
        check_eq("rst_data", 64'(rec_if.rec_data), 64'd0);
        check_eq("rst_event", 64'(event_cnt), 64'd0);
        check_eq("rst_ovf", 64'(overflow_cnt), 64'd0);
        check_eq("rst_level", 64'(fifo_level), 64'd0);
        #10 rst_n = 1'b1;
        tick();
        tick();

        // 1: persistent error logs exactly one record, visible one cycle later
        counter        = 16'h00A5;
        syndrome       = 12'h003;
        enable         = 1'b0;
        error_detected = 1'b1;
        exp_q.push_back({ts_model, 12'h003, 16'h00A5});
        tick();
        check_eq("t1_latency", 64'(rec_if.rec_valid), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check_eq("t1_level", 64'(fifo_level), 64'd1);
        check_eq("t1_event", 64'(event_cnt), 64'd1);
        check_eq("t1_low28", 64'(rec_if.rec_data[27:0]), 64'h003_00A5);
        error_detected = 1'b0;
        tick();
        drain(1);

        // 2: five events into a 4-deep FIFO, then hold and in-order drain
        do_clear();
        ev(16'h1111, 12'h001, 1'b1);
        ev(16'h2222, 12'h002, 1'b1);
        ev(16'h3333, 12'h004, 1'b1);
        ev(16'h4444, 12'h008, 1'b1);
        ev(16'h5555, 12'h010, 1'b0);
        check_eq("t2_level", 64'(fifo_level), 64'd4);
        check_eq("t2_ovf", 64'(overflow_cnt), 64'd1);
        check_eq("t2_event", 64'(event_cnt), 64'd5);
        held = rec_if.rec_data;
        tick();
        tick();
        check_eq("t2_hold", 64'(rec_if.rec_data), 64'(held));
        drain(4);

        // 3: enable masks the error; dropping enable with error held logs once
        do_clear();
        enable         = 1'b1;
        error_detected = 1'b1;
        counter        = 16'hBEEF;
        syndrome       = 12'h5A5;
        for (int i = 0; i < 3; i++) tick();
        check_eq("t3_masked_lvl", 64'(fifo_level), 64'd0);
        check_eq("t3_masked_evt", 64'(event_cnt), 64'd0);
        enable = 1'b0;
        exp_q.push_back({ts_model, 12'h5A5, 16'hBEEF});
        tick();
        tick();
        check_eq("t3_level", 64'(fifo_level), 64'd1);
        check_eq("t3_event", 64'(event_cnt), 64'd1);
        error_detected = 1'b0;
        tick();
        drain(1);

        // 4: full FIFO, event coinciding with a pop is accepted
        do_clear();
        ev(16'h0A01, 12'h100, 1'b1);
        ev(16'h0A02, 12'h200, 1'b1);
        ev(16'h0A03, 12'h300, 1'b1);
        ev(16'h0A04, 12'h400, 1'b1);
        counter          = 16'h0A05;
        syndrome         = 12'h500;
        error_detected   = 1'b1;
        rec_if.rec_ready = 1'b1;
        check_eq("t4_head", 64'(rec_if.rec_data), 64'(exp_q.pop_front()));
        exp_q.push_back({ts_model, 12'h500, 16'h0A05});
        tick();
        rec_if.rec_ready = 1'b0;
        error_detected   = 1'b0;
        check_eq("t4_level", 64'(fifo_level), 64'd4);
        check_eq("t4_ovf", 64'(overflow_cnt), 64'd0);
        check_eq("t4_event", 64'(event_cnt), 64'd5);
        tick();
        drain(4);

        // 5: clear wins over a same-cycle event, and that event is not re-logged
        do_clear();
        ev(16'h0C01, 12'h0C1, 1'b1);
        ev(16'h0C02, 12'h0C2, 1'b1);
        clear          = 1'b1;
        error_detected = 1'b1;
        counter        = 16'h0C03;
        tick();
        clear = 1'b0;
        exp_q.delete();
        check_eq("t5_valid", 64'(rec_if.rec_valid), 64'd0);
        check_eq("t5_level", 64'(fifo_level), 64'd0);
        check_eq("t5_event", 64'(event_cnt), 64'd0);
        check_eq("t5_ovf", 64'(overflow_cnt), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        check_eq("t5_nolog_lvl", 64'(fifo_level), 64'd0);
        check_eq("t5_nolog_evt", 64'(event_cnt), 64'd0);
        error_detected = 1'b0;
        tick();

        // 6: asynchronous reset with records queued, then logging resumes
        ev(16'h0D01, 12'h0D1, 1'b1);
        ev(16'h0D02, 12'h0D2, 1'b1);
        ev(16'h0D03, 12'h0D3, 1'b1);
        check_eq("t6_pre_level", 64'(fifo_level), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_eq("t6_valid", 64'(rec_if.rec_valid), 64'd0);
        check_eq("t6_level", 64'(fifo_level), 64'd0);
        check_eq("t6_event", 64'(event_cnt), 64'd0);
        check_eq("t6_ovf", 64'(overflow_cnt), 64'd0);
        #3 rst_n = 1'b1;
        tick();
        ev(16'h0E01, 12'h0E1, 1'b1);
        check_eq("t6_resume_evt", 64'(event_cnt), 64'd1);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
